// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared constants, state encoding and a small helper for the 4x4 keypad
// scanner. Imported by keypad_matrix_scan and keypad_scanner.
// No ports (package).
// -----------------------------------------------------------------------------
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int KEY_W    = 4;

   // Key count per scan ranges 0..16, so it needs five bits.
   localparam int KEYCNT_W = $clog2(NUM_ROWS * NUM_COLS + 1);

   // Column 0 is the first column driven after reset.
   localparam logic [NUM_COLS-1:0] COL_RESET = 4'b0001;

   // Debounce FSM states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DEB    = 2'd1,
      REPORT = 2'd2,
      HELD   = 2'd3
   } keyState_t;

   // Converts the one-hot column drive into a column index.
   function automatic logic [1:0] colIndex(input logic [NUM_COLS-1:0] col);
      colIndex = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (col[c]) begin
            colIndex = 2'(c);
         end
      end
   endfunction

endpackage

// File: rtl/keypad_matrix_scan.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scan
// Drives the keypad columns one at a time, synchronises the row lines and
// accumulates the hits of one full four-column scan into a summary.
// Ports:
//   clk        in   system clock
//   reset_p    in   synchronous active-high reset
//   row_in     in   [3:0] raw row lines (asynchronous)
//   col_out    out  [3:0] one-hot column drive
//   scan_done  out  1-cycle pulse when a full scan summary is ready
//   key_cnt    out  [4:0] number of pressed intersections in the last scan
//   key_code   out  [3:0] row*4+col of the hit (meaningful when key_cnt==1)
// -----------------------------------------------------------------------------
module keypad_matrix_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 125000
) (
   input  logic                clk,
   input  logic                reset_p,
   input  logic [NUM_ROWS-1:0] row_in,
   output logic [NUM_COLS-1:0] col_out,
   output logic                scan_done,
   output logic [KEYCNT_W-1:0] key_cnt,
   output logic [KEY_W-1:0]    key_code
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [NUM_ROWS-1:0] r_rowMeta;
   logic [NUM_ROWS-1:0] r_rowSync;
   logic [DIV_W-1:0]    r_divCnt;
   logic [NUM_COLS-1:0] r_col;
   logic [KEYCNT_W-1:0] r_accCnt;
   logic [KEY_W-1:0]    r_accCode;
   logic                r_scanDone;
   logic [KEYCNT_W-1:0] r_keyCnt;
   logic [KEY_W-1:0]    r_keyCode;

   logic                w_divTerm;
   logic [2:0]          w_colHitCnt;
   logic [1:0]          w_hitRow;
   logic [KEYCNT_W-1:0] w_sumCnt;
   logic [KEY_W-1:0]    w_sumCode;

   // Two-flop synchroniser for the asynchronous row lines. Because SCAN_DIV
   // is at least 4, the synchronised rows have settled for the current column
   // by the time the divider reaches its terminal count.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         r_rowMeta <= '0;
         r_rowSync <= '0;
      end else begin
         r_rowMeta <= row_in;
         r_rowSync <= r_rowMeta;
      end
   end

   assign w_divTerm = (r_divCnt == DIV_LAST);

   // Counts the rows asserted for the current column and remembers which row
   // was hit; the remembered code only matters when exactly one key is down.
   always_comb begin
      w_colHitCnt = '0;
      w_hitRow    = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (r_rowSync[r]) begin
            w_colHitCnt = w_colHitCnt + 3'd1;
            w_hitRow    = 2'(r);
         end
      end
   end

   // Running totals including the column being sampled right now.
   assign w_sumCnt  = r_accCnt + KEYCNT_W'(w_colHitCnt);
   assign w_sumCode = (w_colHitCnt != 3'd0) ? {w_hitRow, colIndex(r_col)} : r_accCode;

   // Divider, column rotation and per-scan accumulation. At terminal count
   // the current column is folded into the totals and the drive moves on;
   // the last column closes the scan and publishes the summary for one cycle.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         r_divCnt   <= '0;
         r_col      <= COL_RESET;
         r_accCnt   <= '0;
         r_accCode  <= '0;
         r_scanDone <= 1'b0;
         r_keyCnt   <= '0;
         r_keyCode  <= '0;
      end else begin
         r_scanDone <= 1'b0;
         if (w_divTerm) begin
            r_divCnt <= '0;
            r_col    <= {r_col[NUM_COLS-2:0], r_col[NUM_COLS-1]};
            if (r_col[NUM_COLS-1]) begin
               r_scanDone <= 1'b1;
               r_keyCnt   <= w_sumCnt;
               r_keyCode  <= w_sumCode;
               r_accCnt   <= '0;
               r_accCode  <= '0;
            end else begin
               r_accCnt  <= w_sumCnt;
               r_accCode <= w_sumCode;
            end
         end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
         end
      end
   end

   assign col_out   = r_col;
   assign scan_done = r_scanDone;
   assign key_cnt   = r_keyCnt;
   assign key_code  = r_keyCode;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// 4x4 matrix keypad scanner with press and release debounce. Reports each
// qualified single-key press once, as a key code with a 1-cycle valid pulse.
// Ports:
//   clk           in   system clock
//   reset_p       in   synchronous active-high reset
//   row_in        in   [3:0] keypad rows, active-high, asynchronous
//   col_out       out  [3:0] one-hot column drive
//   data_Keypad   out  [3:0] last reported key code, held until next report
//   valid_Keypad  out  1-cycle pulse, data_Keypad valid in the same cycle
//   key_held      out  high while a reported key is not yet released
// -----------------------------------------------------------------------------
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 125000,
   parameter int DEBOUNCE_SCANS = 8
) (
   input  logic                clk,
   input  logic                reset_p,
   input  logic [NUM_ROWS-1:0] row_in,
   output logic [NUM_COLS-1:0] col_out,
   output logic [KEY_W-1:0]    data_Keypad,
   output logic                valid_Keypad,
   output logic                key_held
);

   localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SCANS - 1);

   keyState_t           r_state;
   keyState_t           w_nextState;
   logic [KEY_W-1:0]    r_cand;
   logic [KEY_W-1:0]    w_nextCand;
   logic [DEB_W-1:0]    r_stableCnt;
   logic [DEB_W-1:0]    w_nextStable;
   logic [DEB_W-1:0]    r_relCnt;
   logic [DEB_W-1:0]    w_nextRel;
   logic [KEY_W-1:0]    r_data;
   logic                r_valid;

   logic                w_scanDone;
   logic [KEYCNT_W-1:0] w_keyCnt;
   logic [KEY_W-1:0]    w_keyCode;
   logic                w_single;

   keypad_matrix_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_matrixScan (
      .clk       (clk),
      .reset_p   (reset_p),
      .row_in    (row_in),
      .col_out   (col_out),
      .scan_done (w_scanDone),
      .key_cnt   (w_keyCnt),
      .key_code  (w_keyCode)
   );

   assign w_single = (w_keyCnt == KEYCNT_W'(1));

   // Debounce state and counters. Counters are compared against the last
   // value before incrementing, so they never need to hold more than
   // DEBOUNCE_SCANS and cannot wrap.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         r_state     <= IDLE;
         r_cand      <= '0;
         r_stableCnt <= '0;
         r_relCnt    <= '0;
      end else begin
         r_state     <= w_nextState;
         r_cand      <= w_nextCand;
         r_stableCnt <= w_nextStable;
         r_relCnt    <= w_nextRel;
      end
   end

   // Next-state logic. Everything except REPORT waits for a completed scan;
   // REPORT lasts one cycle so the valid pulse is exactly one cycle wide.
   always_comb begin
      w_nextState  = r_state;
      w_nextCand   = r_cand;
      w_nextStable = r_stableCnt;
      w_nextRel    = r_relCnt;
      case (r_state)
         IDLE: begin
            if (w_scanDone && w_single) begin
               w_nextCand   = w_keyCode;
               w_nextStable = DEB_W'(1);
               w_nextState  = (DEBOUNCE_SCANS == 1) ? REPORT : DEB;
            end
         end
         DEB: begin
            if (w_scanDone) begin
               if (w_single && (w_keyCode == r_cand)) begin
                  if (r_stableCnt == DEB_LAST) begin
                     w_nextState = REPORT;
                  end
                  w_nextStable = r_stableCnt + DEB_W'(1);
               end else begin
                  w_nextState  = IDLE;
                  w_nextStable = '0;
               end
            end
         end
         REPORT: begin
            w_nextState  = HELD;
            w_nextStable = '0;
            w_nextRel    = '0;
         end
         HELD: begin
            if (w_scanDone) begin
               if (w_keyCnt == '0) begin
                  if (r_relCnt == DEB_LAST) begin
                     w_nextState = IDLE;
                     w_nextRel   = '0;
                  end else begin
                     w_nextRel = r_relCnt + DEB_W'(1);
                  end
               end else begin
                  w_nextRel = '0;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Output registers. Data and valid are loaded on the edge that enters
   // REPORT, so the pulse lines up with the REPORT cycle and the data stays
   // put until the next report.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if ((w_nextState == REPORT) && (r_state != REPORT)) begin
            r_data  <= w_nextCand;
            r_valid <= 1'b1;
         end
      end
   end

   assign data_Keypad  = r_data;
   assign valid_Keypad = r_valid;
   assign key_held     = (r_state == HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// The pressed-key set is a 16-bit mask that changes only at scan boundaries;
// a scan-level reference model predicts reports, held status and data.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int SCAN_DIV  = 4;
   localparam int DEB_SCANS = 3;
   localparam int SCAN_CYC  = 4 * SCAN_DIV;

   logic       clk;
   logic       reset_p;
   logic [3:0] rowIn;
   logic [3:0] colOut;
   logic [3:0] dataKeypad;
   logic       validKeypad;
   logic       keyHeld;

   int checksTotal;
   int checksPassed;

   // Reference model state, scan granularity.
   bit mHeld;
   int mRun;
   int mCand;
   int mRel;
   bit mPulse;
   int mLastData;

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEB_SCANS)
   ) dut (
      .clk          (clk),
      .reset_p      (reset_p),
      .row_in       (rowIn),
      .col_out      (colOut),
      .data_Keypad  (dataKeypad),
      .valid_Keypad (validKeypad),
      .key_held     (keyHeld)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it if the values differ.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checksTotal++;
      if (observed == expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Clears the reference model, mirroring what a reset means for the user.
   task automatic modelReset();
      mHeld     = 1'b0;
      mRun      = 0;
      mCand     = 0;
      mRel      = 0;
      mPulse    = 1'b0;
      mLastData = 0;
   endtask

   // Applies the rules for one completed scan whose pressed set was mask.
   task automatic modelScan(input logic [15:0] mask);
      int cnt;
      int code;
      cnt  = $countones(mask);
      code = 0;
      for (int i = 0; i < 16; i++) begin
         if (mask[i]) code = i;
      end
      mPulse = 1'b0;
      if (mHeld) begin
         if (cnt == 0) begin
            mRel = mRel + 1;
            if (mRel == DEB_SCANS) begin
               mHeld = 1'b0;
               mRel  = 0;
            end
         end else begin
            mRel = 0;
         end
      end else begin
         if (mRun > 0 && cnt == 1 && code == mCand) begin
            mRun = mRun + 1;
         end else if (mRun == 0 && cnt == 1) begin
            mCand = code;
            mRun  = 1;
         end else begin
            mRun = 0;
         end
         if (mRun == DEB_SCANS) begin
            mPulse    = 1'b1;
            mLastData = mCand;
            mHeld     = 1'b1;
            mRun      = 0;
            mRel      = 0;
         end
      end
   endtask

   // Synchronous reset for two edges; leaves the bench at the negedge of the
   // first cycle of a fresh scan.
   task automatic doReset();
      reset_p = 1'b1;
      rowIn   = '0;
      repeat (2) @(negedge clk);
      checkOutput("resetCol", int'(colOut), 1);
      checkOutput("resetData", int'(dataKeypad), 0);
      checkOutput("resetValid", int'(validKeypad), 0);
      checkOutput("resetHeld", int'(keyHeld), 0);
      reset_p = 1'b0;
      modelReset();
   endtask

   // Runs one full scan with the given pressed-key mask, checking column
   // rotation, the report pulse, held status and data against the model.
   task automatic applyStimulus(input logic [15:0] mask);
      bit expPulse;
      int expData;
      bit expHeld;
      int extra;
      int ci;
      expPulse = mPulse;
      expData  = mLastData;
      expHeld  = mHeld;
      extra    = 0;
      for (int k = 0; k < SCAN_CYC; k++) begin
         ci = 0;
         for (int c = 0; c < 4; c++) begin
            if (colOut[c]) ci = c;
         end
         for (int r = 0; r < 4; r++) begin
            rowIn[r] = mask[r * 4 + ci];
         end
         if (k % SCAN_DIV == 0) begin
            checkOutput("colOut", int'(colOut), 1 << (k / SCAN_DIV));
         end
         if (k == 1) begin
            checkOutput("validPulse", int'(validKeypad), int'(expPulse));
            if (expPulse) checkOutput("pulseData", int'(dataKeypad), expData);
         end else if (validKeypad) begin
            extra++;
         end
         if (k == SCAN_CYC / 2) begin
            checkOutput("keyHeld", int'(keyHeld), int'(expHeld));
         end
         @(negedge clk);
      end
      checkOutput("extraPulses", extra, 0);
      checkOutput("dataHold", int'(dataKeypad), expData);
      modelScan(mask);
   endtask

   task automatic repeatScans(input logic [15:0] mask, input int n);
      for (int i = 0; i < n; i++) applyStimulus(mask);
   endtask

   initial begin
      logic [15:0] rmask;
      logic [15:0] prevMask;
      int          choice;
      checksTotal  = 0;
      checksPassed = 0;
      reset_p      = 1'b1;
      rowIn        = '0;
      modelReset();
      @(negedge clk);

      // Reset values and column rotation.
      doReset();
      repeatScans(16'h0000, 2);

      // Steady key 9 (row 2, column 1) for 20 scans.
      repeatScans(16'h0200, 20);
      repeatScans(16'h0000, DEB_SCANS);

      // Bounce: 2 present, 1 absent, 2 present, absent.
      repeatScans(16'h0200, 2);
      repeatScans(16'h0000, 1);
      repeatScans(16'h0200, 2);
      repeatScans(16'h0000, 2);

      // Multi-key 0+5, then 5 alone.
      repeatScans(16'h0021, 5);
      repeatScans(16'h0020, 3);
      repeatScans(16'h0000, DEB_SCANS + 1);

      // Release qualification with key 9 then key 3.
      repeatScans(16'h0200, 4);
      repeatScans(16'h0000, 2);
      repeatScans(16'h0008, 4);
      repeatScans(16'h0000, 3);
      repeatScans(16'h0008, 3);
      repeatScans(16'h0000, DEB_SCANS + 1);

      // Reset in the middle of debouncing key 7.
      repeatScans(16'h0080, 2);
      doReset();
      repeatScans(16'h0080, 3);
      repeatScans(16'h0000, DEB_SCANS + 1);

      // Randomised segments: repeated masks of random kinds and lengths.
      prevMask = 16'h0000;
      for (int seg = 0; seg < 45; seg++) begin
         choice = int'($urandom_range(0, 99));
         if (choice < 35) begin
            rmask = prevMask;
         end else if (choice < 55) begin
            rmask = 16'h0000;
         end else if (choice < 85) begin
            rmask = 16'h0001 << $urandom_range(0, 15);
         end else begin
            rmask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
         end
         prevMask = rmask;
         repeatScans(rmask, int'($urandom_range(1, 6)));
      end
      repeatScans(16'h0000, DEB_SCANS + 1);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
4x4 matrix keypad scanner with debounce, upstream of system_control. It feeds system_control's keypad input pair, data_Keypad and valid_Keypad. It drives one column at a time, samples the rows, and qualifies a single-key press over several full scans. It then emits one 4-bit key code with a 1-cycle valid pulse per press. The key must be released, with debounce, before another press is reported.

Parameters:
SCAN_DIV, 125000, clk cycles each column is driven before its rows are sampled (min 4)
DEBOUNCE_SCANS, 8, consecutive identical full scans required for a press, and consecutive empty scans required for a release (min 1)

Ports:
clk  input  1  system clock; single clock domain
reset_p  input  1  synchronous, active-high reset
row_in  input  4  keypad row lines; active-high; asynchronous to clk
col_out  output  4  one-hot column drive; active-high
data_Keypad  output  4  last reported key code = row*4 + col; held until next report
valid_Keypad  output  1  1-cycle pulse; data_Keypad is valid in the same cycle
key_held  output  1  high while a reported key has not yet been debounce-released

Behaviour:
- Reset (synchronous, reset_p sampled high at posedge clk):
  - col_out=4'b0001, data_Keypad=0, valid_Keypad=0, key_held=0.
  - State IDLE; all counters and the synchroniser cleared.
  - Applies from any state, including mid-debounce and mid-held.
- Synchroniser: row_in passes through a 2-FF synchroniser before use.
- Column scan:
  - Divider counts 0..SCAN_DIV-1.
  - At terminal count: sample the synchronised rows for the current column, then rotate col_out left (0001→0010→0100→1000→0001).
- Scan end: the terminal count while col_out=1000 closes a full scan, producing a 1-cycle scan_done.
  - Summary: key_cnt = number of asserted row/col intersections (0..16).
  - key_code = the single hit's row*4+col; it is valid only when key_cnt==1.
- FSM advances only on scan_done:
  - IDLE:
    - key_cnt==1 → cand<=key_code, stable_cnt<=1, go DEB.
    - Otherwise stay.
    - If DEBOUNCE_SCANS==1, skip DEB and report immediately (REPORT).
  - DEB:
    - key_cnt==1 and key_code==cand → stable_cnt++; when the new value equals DEBOUNCE_SCANS → REPORT.
    - Any other result (none, multiple, different key) → IDLE, stable_cnt<=0.
  - REPORT (one cycle, not gated by scan_done): data_Keypad<=cand, valid_Keypad<=1 for exactly one cycle, go HELD.
  - HELD:
    - key_held=1.
    - key_cnt==0 → rel_cnt++; when it equals DEBOUNCE_SCANS → IDLE, rel_cnt<=0.
    - Any nonzero key_cnt → rel_cnt<=0.
    - No auto-repeat.
- Latency: valid_Keypad rises 1 cycle after the scan_done that completes the DEBOUNCE_SCANS-th matching scan.
- Multi-key: never reported. Keys pressed while HELD are ignored until release completes.
- stable_cnt and rel_cnt are sized $clog2(DEBOUNCE_SCANS+1). The divider is sized $clog2(SCAN_DIV). No wrap is possible because both counters are compared before incrementing.

Decomposition:
- Package keypad_pkg:
  - NUM_ROWS=4, NUM_COLS=4, KEY_W=4.
  - FSM state encodings IDLE/DEB/REPORT/HELD.
  - Column reset pattern 4'b0001.
- Sub-module keypad_matrix_scan:
  - Contains the divider, column rotation, row synchroniser and per-scan accumulation.
  - Outputs col_out, scan_done, key_cnt, key_code.
- Top: debounce FSM and output registers.

Test Plan:
(SCAN_DIV=4, DEBOUNCE_SCANS=3; one full scan = 16 cycles)
1. Reset: hold reset_p 2 cycles → col_out=0001, data_Keypad=0, valid_Keypad=0, key_held=0. Release reset → col_out advances every 4 cycles through 0010, 0100, 1000, 0001.
2. Steady single key: assert row 2 whenever col 1 is driven, held 20 scans → exactly one valid_Keypad pulse, data_Keypad=4'h9, 1 cycle after the 3rd completed scan. key_held=1 thereafter, no repeat.
3. Bounce: key 9 present for 2 scans, absent 1, present 2, absent → no valid_Keypad pulse; FSM returns to IDLE.
4. Multi-key: codes 0 and 5 held together for 5 scans → no pulse. Release code 0, keep 5 → one pulse with data=4'h5 after 3 scans.
5. Release qualification:
   - After code 9 is reported, release for 2 scans, then press code 3 for 4 scans → no pulse.
   - Release for 3 scans, then press code 3 for 3 scans → one pulse with data=4'h3.
   - data_Keypad holds 4'h9 until that pulse.
6. Reset mid-operation: pulse reset_p after 2 matching scans of code 7 (in DEB) → state cleared, col_out=0001. The pulse then appears only after 3 fresh full scans of code 7, with data=4'h7.
